// File: rtl/dmem_responder_if.sv
// Load/store bus between the MIPS datapath (master) and the data-memory
// responder (slave), including the responder's status and perf counters.
interface dmem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        stall;
    logic        err_misalign;
    logic        err_conflict;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    modport master (
        output mem_read, mem_write, address, write_data,
        input  read_data, stall, err_misalign, err_conflict, rd_count, wr_count
    );

    modport slave (
        input  mem_read, mem_write, address, write_data,
        output read_data, stall, err_misalign, err_conflict, rd_count, wr_count
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with configurable access latency; holds the
// datapath through stall. Load/store counters exist only with DMEM_RESPONDER_PERF_EN.
module dmem_responder #(
    parameter int DEPTH     = 256,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 2
) (
    input logic         clk,
    input logic         reset,
    dmem_responder_if.slave bus
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
    localparam logic LAT_ZERO = (LATENCY == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   op_write_q;
    logic                   misalign_q;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [31:0]            wdata_q;
    logic [31:0]            read_data_q;
    logic                   err_misalign_q;
    logic                   err_conflict_q;
    logic [31:0]            mem_q [DEPTH];

    logic                   req_s;
    logic                   stall_s;
    logic                   done_entry_s;
    logic                   cur_write_s;
    logic                   cur_mis_s;
    logic [ADDR_BITS-1:0]   cur_idx_s;
    logic [31:0]            cur_wdata_s;
    logic                   mem_we_s;
    logic                   unused_addr_s;

    assign req_s         = bus.mem_read | bus.mem_write;
    assign unused_addr_s = ^bus.address[31:ADDR_BITS+2];

    // Request seen by the completing edge: live inputs in IDLE (zero latency), latched copy otherwise.
    always_comb begin
        cur_write_s  = op_write_q;
        cur_mis_s    = misalign_q;
        cur_idx_s    = idx_q;
        cur_wdata_s  = wdata_q;
        done_entry_s = 1'b0;
        case (state_q)
            IDLE: begin
                cur_write_s  = bus.mem_write;
                cur_mis_s    = |bus.address[1:0];
                cur_idx_s    = bus.address[ADDR_BITS+1:2];
                cur_wdata_s  = bus.write_data;
                done_entry_s = req_s & LAT_ZERO;
            end
            BUSY: begin
                done_entry_s = (cnt_q == '0);
            end
            default: begin
                done_entry_s = 1'b0;
            end
        endcase
    end

    // Stall is combinational in IDLE so the PC never moves on the request cycle; reset forces it low.
    always_comb begin
        stall_s = 1'b0;
        case (state_q)
            IDLE:    stall_s = req_s;
            BUSY:    stall_s = 1'b1;
            default: stall_s = 1'b0;
        endcase
        if (!reset) begin
            stall_s = 1'b0;
        end else begin
            stall_s = stall_s;
        end
    end

    assign mem_we_s = reset & done_entry_s & cur_write_s & ~cur_mis_s;

    // Request latch, wait counter, registered load data and sticky error flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            op_write_q     <= 1'b0;
            misalign_q     <= 1'b0;
            idx_q          <= '0;
            wdata_q        <= 32'h0000_0000;
            read_data_q    <= 32'h0000_0000;
            err_misalign_q <= 1'b0;
            err_conflict_q <= 1'b0;
        end else begin
            if (done_entry_s) begin
                read_data_q <= (cur_write_s || cur_mis_s) ? 32'h0000_0000 : mem_q[cur_idx_s];
            end
            case (state_q)
                IDLE: begin
                    if (req_s) begin
                        op_write_q <= bus.mem_write;
                        misalign_q <= |bus.address[1:0];
                        idx_q      <= bus.address[ADDR_BITS+1:2];
                        wdata_q    <= bus.write_data;
                        if (|bus.address[1:0]) begin
                            err_misalign_q <= 1'b1;
                        end
                        if (bus.mem_read && bus.mem_write) begin
                            err_conflict_q <= 1'b1;
                        end
                        if (LAT_ZERO) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Storage array; deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[cur_idx_s] <= cur_wdata_s;
        end
    end

    assign bus.read_data    = read_data_q;
    assign bus.stall        = stall_s;
    assign bus.err_misalign = err_misalign_q;
    assign bus.err_conflict = err_conflict_q;

`ifdef DMEM_RESPONDER_PERF_EN
    logic [15:0] rd_count_q;
    logic [15:0] wr_count_q;

    // Saturating completion counters; a conflicting access counts as a store.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count_q <= 16'h0000;
            wr_count_q <= 16'h0000;
        end else if (done_entry_s) begin
            if (!cur_write_s && (rd_count_q != 16'hFFFF)) begin
                rd_count_q <= rd_count_q + 16'h0001;
            end
            if (cur_write_s && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'h0001;
            end
        end
    end

    assign bus.rd_count = rd_count_q;
    assign bus.wr_count = wr_count_q;
`else
    assign bus.rd_count = 16'h0000;
    assign bus.wr_count = 16'h0000;
`endif

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder for the MIPS datapath, sitting on the datapath's load/store interface: MemRead, MemWrite, ALU_result as the address, and rt data as the write data.
- Models a memory with a configurable access latency. It holds the datapath via a stall output (datapath PC_en = ~stall) until the access completes.
- It is the responder end of the load/store interface; the datapath is the initiator.

Parameters:
- DEPTH, 256, number of 32-bit words; power of 2.
- ADDR_BITS, 8, log2(DEPTH); word index = address[ADDR_BITS+1:2].
- LATENCY, 2, extra wait cycles per access, >= 0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- mem_read  in  1  load request (MemRead).
- mem_write  in  1  store request (MemWrite).
- address  in  32  byte address (ALU_result).
- write_data  in  32  store data (reg_read_data2).
- read_data  out  32  load data; valid in DONE.
- stall  out  1  high = datapath must hold PC and suppress writeback.
- err_misalign  out  1  sticky: an access had address[1:0] != 0.
- err_conflict  out  1  sticky: mem_read and mem_write were high together.
- rd_count  out  16  completed loads (optional feature).
- wr_count  out  16  completed stores (optional feature).

Behaviour:
- Reset (reset=0, async): state=IDLE, read_data=0, err_*=0, counters=0, latched request discarded. Memory array is not cleared. A reset mid-access aborts it and no write occurs.
- req = mem_read | mem_write.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall = req (combinational), so the PC never advances on the request cycle.
  - On req, latch op, word index and write_data.
  - Next state is BUSY with cnt=LATENCY-1, or DONE directly if LATENCY=0.
- BUSY:
  - stall=1.
  - cnt decrements each cycle; when cnt==0, next state is DONE.
  - Inputs are ignored here; the datapath holds them stable because the PC is frozen.
- DONE:
  - stall=0 for exactly one cycle; next state is always IDLE.
  - read_data is registered on entry to DONE: mem[idx] for a read, 0 for a write.
  - A store commits to the array on the BUSY/IDLE->DONE edge.
  - The datapath's register writeback and PC update occur at the end of the DONE cycle.
- Total cycles per memory instruction = LATENCY+2. Non-memory instructions never stall (IDLE with req=0).
- Back-to-back memory instructions: the edge leaving DONE also loads the next instruction. IDLE then sees the new req and re-arms; no request is lost or double-serviced.
- Simultaneous read and write: treated as a write, err_conflict is set, and read_data=0.
- Misaligned address: err_misalign is set; a store is dropped and a load returns 0. The FSM timing is unchanged.
- Addresses beyond DEPTH alias modulo DEPTH; upper address bits are ignored.
- read_data holds its value outside DONE until the next access completes.

Optional Feature:
- Macro DMEM_RESPONDER_PERF_EN.
- Defined:
  - rd_count increments once per completed load, i.e. on entry to DONE with op=read.
  - wr_count increments once per completed store.
  - Both counters saturate at 16'hFFFF and clear on reset.
- Undefined: rd_count and wr_count are tied to 0 and no counter flops are generated.

Test Plan:
- LATENCY=2, store 32'hDEADBEEF to 0x10 then load 0x10:
  - stall high for 3 cycles per access, then low for 1 cycle.
  - The load's DONE cycle shows read_data=32'hDEADBEEF.
  - Each access takes 4 cycles.
- LATENCY=0, load immediately after a store to the same address 0x20 (data 32'h12345678): read_data=32'h12345678, each access takes 2 cycles, no extra stall.
- Store to address 0x13 (misaligned):
  - err_misalign=1, memory word 4 unchanged.
  - A subsequent load from 0x10 returns the prior value.
  - Timing is unchanged.
- mem_read=mem_write=1, address 0x40, data 32'hA5A5A5A5: err_conflict=1, word 16 = 32'hA5A5A5A5, read_data=0.
- Reset asserted during BUSY of a store of 32'hFFFFFFFF to 0x08:
  - stall drops immediately; state is IDLE and word 2 is unchanged.
  - After release, a load from 0x08 returns the old value.
- With DMEM_RESPONDER_PERF_EN defined, 3 loads, 2 stores and 5 ALU instructions: rd_count=3, wr_count=2. Without the macro, both read 0.
